f_select_divider: RTL



---
 rtl/f_select_divider_pkg.sv | 48 ++++
 rtl/f_ratio_rom.sv | 54 +++++
 rtl/f_select_divider.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/f_select_divider_pkg.sv
// rtl/f_select_divider_pkg.sv - shared widths, depth and half-period ratio table
package f_select_divider_pkg;

  localparam int WIDTH_DIR_DEF  = 5;
  localparam int WIDTH_DATA_DEF = 28;
  localparam int DEPTH_DEF      = 28;

  // Half-period count (in clk cycles) for each select index.
  // Out-of-range indices and zero entries yield 1 so the counter
  // terminal (half-1) can never underflow.
  function automatic logic [31:0] ratio_half(input logic [31:0] idx);
    logic [31:0] v;
    case (idx)
      32'd0:   v = 32'd50_000_000;
      32'd1:   v = 32'd5_000_000;
      32'd2:   v = 32'd2_500_000;
      32'd3:   v = 32'd2_000_000;
      32'd4:   v = 32'd1_000_000;
      32'd5:   v = 32'd500_000;
      32'd6:   v = 32'd250_000;
      32'd7:   v = 32'd200_000;
      32'd8:   v = 32'd100_000;
      32'd9:   v = 32'd66_667;
      32'd10:  v = 32'd50_000;
      32'd11:  v = 32'd5_000;
      32'd12:  v = 32'd2_500;
      32'd13:  v = 32'd2_000;
      32'd14:  v = 32'd1_000;
      32'd15:  v = 32'd665;
      32'd16:  v = 32'd500;
      32'd17:  v = 32'd250;
      32'd18:  v = 32'd200;
      32'd19:  v = 32'd100;
      32'd20:  v = 32'd65;
      32'd21:  v = 32'd50;
      32'd22:  v = 32'd12;
      32'd23:  v = 32'd10;
      32'd24:  v = 32'd8;
      32'd25:  v = 32'd6;
      32'd26:  v = 32'd4;
      32'd27:  v = 32'd2;
      default: v = 32'd1;
    endcase
    if (v == 32'd0) v = 32'd1;
    return v;
  endfunction

endpackage

// File: rtl/f_ratio_rom.sv
// rtl/f_ratio_rom.sv - registered ratio table lookup with invalid-index flag
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   dir       : select index, sampled every cycle
//   data      : half-period count for the index sampled last cycle
//   invalid   : high when the index sampled last cycle is >= DEPTH
module f_ratio_rom
  import f_select_divider_pkg::*;
#(
  parameter int WIDTH_DIR  = WIDTH_DIR_DEF,
  parameter int WIDTH_DATA = WIDTH_DATA_DEF,
  parameter int DEPTH      = DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH_DIR-1:0]  dir,
  output logic [WIDTH_DATA-1:0] data,
  output logic                  invalid
);

  localparam logic [31:0] DEPTH_U = 32'(DEPTH);
  localparam logic [WIDTH_DATA-1:0] HALF0_RAW = WIDTH_DATA'(ratio_half(32'd0));
  localparam logic [WIDTH_DATA-1:0] HALF0 =
    (HALF0_RAW == '0) ? WIDTH_DATA'(1) : HALF0_RAW;

  logic [31:0]           dir_ext;
  logic [WIDTH_DATA-1:0] lookup;
  logic [WIDTH_DATA-1:0] data_d, data_q;
  logic                  invalid_d, invalid_q;

  assign dir_ext = 32'(dir);

  always_comb begin
    lookup = WIDTH_DATA'(ratio_half(dir_ext));
    if (lookup == '0) lookup = WIDTH_DATA'(1);
    invalid_d = (dir_ext >= DEPTH_U);
    // Invalid indices keep the last good data; the consumer ignores it anyway.
    data_d = invalid_d ? data_q : lookup;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= HALF0;
      invalid_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      invalid_q <= invalid_d;
    end
  end

  assign data    = data_q;
  assign invalid = invalid_q;

endmodule

// File: rtl/f_select_divider.sv
// rtl/f_select_divider.sv - programmable 50% clock divider with glitch-free ratio change
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   dir       : ratio select index
//   en        : count enable (0 freezes counter and outputs)
//   restart   : synchronous phase restart, applies any pending ratio
//   clk_out   : divided clock, period 2*half cycles
//   tick      : one-cycle strobe per half-period terminal
//   sel_done  : one-cycle pulse when a new ratio is applied
//   sel_err   : high while the registered index is out of range
module f_select_divider
  import f_select_divider_pkg::*;
#(
  parameter int WIDTH_DIR  = WIDTH_DIR_DEF,
  parameter int WIDTH_DATA = WIDTH_DATA_DEF,
  parameter int DEPTH      = DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH_DIR-1:0] dir,
  input  logic                 en,
  input  logic                 restart,
  output logic                 clk_out,
  output logic                 tick,
  output logic                 sel_done,
  output logic                 sel_err
);

  localparam logic [WIDTH_DATA-1:0] ONE = WIDTH_DATA'(1);
  localparam logic [WIDTH_DATA-1:0] HALF0_RAW = WIDTH_DATA'(ratio_half(32'd0));
  localparam logic [WIDTH_DATA-1:0] HALF0 = (HALF0_RAW == '0) ? ONE : HALF0_RAW;

  logic [WIDTH_DATA-1:0] rom_data;
  logic                  rom_invalid;

  f_ratio_rom #(
    .WIDTH_DIR (WIDTH_DIR),
    .WIDTH_DATA(WIDTH_DATA),
    .DEPTH     (DEPTH)
  ) u_rom (
    .clk    (clk),
    .rst    (rst),
    .dir    (dir),
    .data   (rom_data),
    .invalid(rom_invalid)
  );

  // Index registered alongside the ROM so it lines up with rom_data.
  logic [WIDTH_DIR-1:0]  dir_d, dir_q;
  logic [WIDTH_DATA-1:0] cnt_d, cnt_q;
  logic                  clk_out_d, clk_out_q;
  logic                  tick_d, tick_q;
  logic                  sel_done_d, sel_done_q;
  logic                  pending_d, pending_q;
  logic [WIDTH_DATA-1:0] new_half_d, new_half_q;
  logic [WIDTH_DIR-1:0]  new_dir_d, new_dir_q;
  logic [WIDTH_DATA-1:0] cur_half_d, cur_half_q;
  logic [WIDTH_DIR-1:0]  cur_dir_d, cur_dir_q;
  logic                  terminal;

  always_comb begin
    dir_d      = dir;
    cnt_d      = cnt_q;
    clk_out_d  = clk_out_q;
    tick_d     = 1'b0;
    sel_done_d = 1'b0;
    pending_d  = pending_q;
    new_half_d = new_half_q;
    new_dir_d  = new_dir_q;
    cur_half_d = cur_half_q;
    cur_dir_d  = cur_dir_q;
    terminal   = en && (cnt_q == cur_half_q - ONE);

    if (restart) begin
      cnt_d     = '0;
      clk_out_d = 1'b0;
      if (pending_q) begin
        cur_half_d = new_half_q;
        cur_dir_d  = new_dir_q;
        pending_d  = 1'b0;
        sel_done_d = 1'b1;
      end
    end else if (en) begin
      // Track the latest valid request; returning to the active index cancels it.
      if (!rom_invalid) begin
        if (dir_q != cur_dir_q) begin
          pending_d  = 1'b1;
          new_half_d = rom_data;
          new_dir_d  = dir_q;
        end else begin
          pending_d = 1'b0;
        end
      end
      if (terminal) begin
        cnt_d     = '0;
        clk_out_d = ~clk_out_q;
        tick_d    = 1'b1;
        // Ratio switches only on a half-period boundary, so no runt pulse.
        // A request arriving this same cycle is picked up next cycle.
        if (pending_q) begin
          cur_half_d = new_half_q;
          cur_dir_d  = new_dir_q;
          pending_d  = 1'b0;
          sel_done_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q      <= '0;
      cnt_q      <= '0;
      clk_out_q  <= 1'b0;
      tick_q     <= 1'b0;
      sel_done_q <= 1'b0;
      pending_q  <= 1'b0;
      new_half_q <= HALF0;
      new_dir_q  <= '0;
      cur_half_q <= HALF0;
      cur_dir_q  <= '0;
    end else begin
      dir_q      <= dir_d;
      cnt_q      <= cnt_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
      sel_done_q <= sel_done_d;
      pending_q  <= pending_d;
      new_half_q <= new_half_d;
      new_dir_q  <= new_dir_d;
      cur_half_q <= cur_half_d;
      cur_dir_q  <= cur_dir_d;
    end
  end

  assign clk_out  = clk_out_q;
  assign tick     = tick_q;
  assign sel_done = sel_done_q;
  assign sel_err  = rom_invalid;

endmodule
